// File: rtl/fpnew_classify_unit_if.sv
// fpnew_classify_unit_if: request/response bundle of the operand classifier.
// info_o per operand, MSB first: {normal, subnormal, zero, inf, nan, signalling, quiet, boxed}.
interface fpnew_classify_unit_if #(
    parameter int unsigned WIDTH   = 64,
    parameter int unsigned NUM_OPS = 2,
    parameter type         TagType = logic
);
    logic [NUM_OPS-1:0][WIDTH-1:0] operands_i;
    logic [2:0]                    fmt_i;
    TagType                        tag_i;
    logic                          in_valid_i;
    logic                          in_ready_o;
    logic                          flush_i;
    logic [NUM_OPS-1:0][7:0]       info_o;
    logic [9:0]                    class_mask_o;
    TagType                        tag_o;
    logic                          out_valid_o;
    logic                          out_ready_i;
    logic                          busy_o;

    modport master (
        output operands_i, fmt_i, tag_i, in_valid_i, flush_i, out_ready_i,
        input  in_ready_o, info_o, class_mask_o, tag_o, out_valid_o, busy_o
    );

    modport slave (
        input  operands_i, fmt_i, tag_i, in_valid_i, flush_i, out_ready_i,
        output in_ready_o, info_o, class_mask_o, tag_o, out_valid_o, busy_o
    );
endinterface

// File: rtl/fpnew_classify_unit.sv
// fpnew_classify_unit: multi-format operand classifier with valid/ready result pipeline.
// Define FPNEW_CLASSIFY_FLUSH_EN to enable the flush_i pipeline kill.
module fpnew_classify_unit #(
    parameter logic [4:0]  FpFmtConfig = '1,
    parameter int unsigned NumOperands = 2,
    parameter int unsigned NumPipeRegs = 1,
    parameter type         TagType     = logic
) (
    input logic                 clk_i,
    input logic                 rst_i,
    fpnew_classify_unit_if.slave io
);
    // Formats: 0 FP32, 1 FP64, 2 FP16, 3 FP8, 4 FP16ALT
    localparam int unsigned WIDTH = FpFmtConfig[1] ? 64 : FpFmtConfig[0] ? 32 :
                                    (FpFmtConfig[2] || FpFmtConfig[4]) ? 16 : 8;
    localparam int unsigned S = NumPipeRegs;

    function automatic logic [6:0] fmt_width(logic [2:0] f);
        return f == 3'd1 ? 7'd64 : f == 3'd0 ? 7'd32 : f == 3'd3 ? 7'd8 : 7'd16;
    endfunction

    function automatic logic [6:0] exp_width(logic [2:0] f);
        return f == 3'd1 ? 7'd11 : (f == 3'd0 || f == 3'd4) ? 7'd8 : 7'd5;
    endfunction

    function automatic logic enabled(logic [2:0] f);
        logic [7:0] cfg;
        cfg = 8'(FpFmtConfig);
        return cfg[f];
    endfunction

    function automatic logic [7:0] classify(logic [WIDTH-1:0] op, logic [2:0] f);
        logic [63:0] x, one, hi, ex, man, emax;
        logic [6:0]  fw, ew, mw;
        logic        boxed, nan, sig;
        x     = 64'(op);
        one   = 64'd1;
        fw    = fmt_width(f);
        ew    = exp_width(f);
        mw    = fw - ew - 7'd1;
        // Bits above the format that must be all-ones for a valid NaN-box
        hi    = (64'hFFFF_FFFF_FFFF_FFFF >> (64 - WIDTH)) & ~((one << fw) - one);
        boxed = (x & hi) == hi;
        emax  = (one << ew) - one;
        ex    = (x >> mw) & emax;
        man   = x & ((one << mw) - one);
        nan   = !boxed || (ex == emax && man != '0);
        sig   = boxed && nan && (man & (one << (mw - 7'd1))) == '0;
        return enabled(f) ? {boxed && ex != '0 && ex != emax, boxed && ex == '0 && man != '0,
                             boxed && ex == '0 && man == '0, boxed && ex == emax && man == '0,
                             nan, sig, nan && !sig, boxed} : 8'h0A;
    endfunction

    function automatic logic sign_bit(logic [WIDTH-1:0] op, logic [2:0] f);
        return |((64'(op) >> (fmt_width(f) - 7'd1)) & 64'd1);
    endfunction

    // i = {normal, subnormal, zero, inf, nan, signalling}
    function automatic logic [9:0] fclass(logic [7:2] i, logic s);
        logic [3:0] idx;
        idx = i[3] ? (i[2] ? 4'd8 : 4'd9) :
              i[4] ? (s ? 4'd0 : 4'd7) :
              i[7] ? (s ? 4'd1 : 4'd6) :
              i[6] ? (s ? 4'd2 : 4'd5) :
              i[5] ? (s ? 4'd3 : 4'd4) : 4'd9;
        return 10'd1 << idx;
    endfunction

    logic [NumOperands-1:0][7:0] c_info;
    logic [9:0]                  c_mask;
    logic [NumOperands-1:0][7:0] info_s [S+1];
    logic [9:0]                  mask_s [S+1];
    TagType                      tag_s  [S+1];
    logic [S:0]                  vld, rdy;
    logic                        busy, flush;

`ifdef FPNEW_CLASSIFY_FLUSH_EN
    assign flush = io.flush_i;
`else
    logic flush_unused;
    assign flush_unused = io.flush_i;
    assign flush = 1'b0;
`endif

    always_comb begin
        for (int n = 0; n < NumOperands; n++) c_info[n] = classify(io.operands_i[n], io.fmt_i);
        c_mask = fclass(c_info[0][7:2], sign_bit(io.operands_i[0], io.fmt_i));
    end

    assign vld[0]    = io.in_valid_i;
    assign info_s[0] = c_info;
    assign mask_s[0] = c_mask;
    assign tag_s[0]  = io.tag_i;

    // Ready ripples back from the output; a stage frees up when it is empty or draining
    always_comb begin
        rdy    = '0;
        rdy[S] = io.out_ready_i;
        busy   = 1'b0;
        for (int i = S; i > 0; i--) begin
            rdy[i-1] = !vld[i] || rdy[i];
            busy     = busy || vld[i];
        end
    end

    for (genvar k = 1; k <= S; k++) begin : g_stage
        logic                        valid_q, valid_d;
        logic [NumOperands-1:0][7:0] info_q;
        logic [9:0]                  mask_q;
        TagType                      tag_q;
        assign valid_d = flush ? 1'b0 : rdy[k-1] ? vld[k-1] : valid_q;
        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                valid_q <= 1'b0;
                info_q  <= '0;
                mask_q  <= '0;
                tag_q   <= '0;
            end else begin
                valid_q <= valid_d;
                if (vld[k-1] && rdy[k-1]) begin
                    info_q <= info_s[k-1];
                    mask_q <= mask_s[k-1];
                    tag_q  <= tag_s[k-1];
                end
            end
        end
        assign vld[k]    = valid_q;
        assign info_s[k] = info_q;
        assign mask_s[k] = mask_q;
        assign tag_s[k]  = tag_q;
    end

    assign io.in_ready_o   = rdy[0] && !flush;
    assign io.out_valid_o  = vld[S];
    assign io.info_o       = info_s[S];
    assign io.class_mask_o = mask_s[S];
    assign io.tag_o        = tag_s[S];
    assign io.busy_o       = busy;
endmodule
